// File: rtl/jk_cmd_debouncer_if.sv
// Button-to-command bus for jk_cmd_debouncer: raw buttons in,
// arbitrated j/k/conflict pulses and debounced levels out.
interface jk_cmd_debouncer_if;
    logic btn_on;
    logic btn_off;
    logic j;
    logic k;
    logic conflict;
    logic on_lvl;
    logic off_lvl;

    modport master (
        output btn_on,
        output btn_off,
        input  j,
        input  k,
        input  conflict,
        input  on_lvl,
        input  off_lvl
    );

    modport slave (
        input  btn_on,
        input  btn_off,
        output j,
        output k,
        output conflict,
        output on_lvl,
        output off_lvl
    );
endinterface

// File: rtl/jk_cmd_debouncer.sv
// Synchronises and debounces two push-buttons and turns each accepted press
// into a one-cycle j/k command; simultaneous presses are dropped and flagged.
module jk_cmd_debouncer #(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    jk_cmd_debouncer_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } db_state_e;

    localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE - 1);

    // Index 0 is the "on" button, index 1 the "off" button.
    logic [1:0]       raw_s;
    logic [1:0]       ff1_r;
    logic [1:0]       s_r;
    logic [1:0]       stable_r;
    logic [1:0]       stable_d_r;
    logic [1:0]       stable_nx_s;
    logic [1:0][7:0]  cnt_r;
    logic [1:0][7:0]  cnt_nx_s;
    logic [1:0]       req_s;
    db_state_e        state_s [2];
    logic             j_r;
    logic             k_r;
    logic             conflict_r;

    assign raw_s = {bus.btn_off, bus.btn_on};
    assign req_s = stable_r & ~stable_d_r;

    // Two-flop synchroniser per button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1_r <= 2'b00;
            s_r   <= 2'b00;
        end else begin
            ff1_r <= raw_s;
            s_r   <= ff1_r;
        end
    end

    // Debounce next-state: a level change needs DEBOUNCE unbroken disagreeing samples
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            stable_nx_s[i] = stable_r[i];
            cnt_nx_s[i]    = 8'd0;
            state_s[i]     = (s_r[i] != stable_r[i]) ? PEND : IDLE;
            case (state_s[i])
                IDLE: begin
                    cnt_nx_s[i] = 8'd0;
                end
                PEND: begin
                    if (cnt_r[i] == CNT_MAX) begin
                        stable_nx_s[i] = s_r[i];
                        cnt_nx_s[i]    = 8'd0;
                    end else begin
                        cnt_nx_s[i] = cnt_r[i] + 8'd1;
                    end
                end
                default: begin
                    stable_nx_s[i] = 1'b0;
                    cnt_nx_s[i]    = 8'd0;
                end
            endcase
        end
    end

    // Debounce state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_r   <= 2'b00;
            stable_d_r <= 2'b00;
            cnt_r      <= '0;
        end else begin
            stable_r   <= stable_nx_s;
            stable_d_r <= stable_r;
            cnt_r      <= cnt_nx_s;
        end
    end

    // Command arbitration: same-edge requests cancel each other
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            j_r        <= 1'b0;
            k_r        <= 1'b0;
            conflict_r <= 1'b0;
        end else begin
            j_r        <= req_s[0] & ~req_s[1];
            k_r        <= req_s[1] & ~req_s[0];
            conflict_r <= req_s[0] & req_s[1];
        end
    end

    assign bus.j        = j_r;
    assign bus.k        = k_r;
    assign bus.conflict = conflict_r;
    assign bus.on_lvl   = stable_r[0];
    assign bus.off_lvl  = stable_r[1];

endmodule

// File: tb/tb_jk_cmd_debouncer.sv
// Self-checking bench for jk_cmd_debouncer: directed scenarios with fixed
// edge expectations plus random button activity against a queue-based model.
module tb_jk_cmd_debouncer;

    localparam int unsigned DB = 4;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    jk_cmd_debouncer_if bus ();

    jk_cmd_debouncer #(.DEBOUNCE(DB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a level is accepted once the last DB synchronised
    // samples all disagree with the current accepted level.
    logic [1:0] m_ff1, m_s, m_lvl, m_lvl_prev;
    logic       m_j, m_k, m_conf;
    bit         hist [2][$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ff1      <= 2'b00;
            m_s        <= 2'b00;
            m_lvl      <= 2'b00;
            m_lvl_prev <= 2'b00;
            m_j        <= 1'b0;
            m_k        <= 1'b0;
            m_conf     <= 1'b0;
            hist[0].delete();
            hist[1].delete();
        end else begin
            automatic logic [1:0] press = m_lvl & ~m_lvl_prev;
            automatic logic [1:0] lvl   = m_lvl;
            m_j    <= press[0] && !press[1];
            m_k    <= press[1] && !press[0];
            m_conf <= press[0] && press[1];
            for (int i = 0; i < 2; i++) begin
                automatic int disagree = 0;
                hist[i].push_back(m_s[i]);
                if (hist[i].size() > DB) void'(hist[i].pop_front());
                foreach (hist[i][n]) if (hist[i][n] != m_lvl[i]) disagree++;
                if (disagree == DB) begin
                    lvl[i] = m_s[i];
                    hist[i].delete();
                end
            end
            m_lvl_prev <= m_lvl;
            m_lvl      <= lvl;
            m_s        <= m_ff1;
            m_ff1      <= {bus.btn_off, bus.btn_on};
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        bus.btn_on  = 1'b0;
        bus.btn_off = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [4:0] act;
        rst_n = 1'b0;
        bus.btn_on  = 1'b1;
        bus.btn_off = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            act = {bus.j, bus.k, bus.conflict, bus.on_lvl, bus.off_lvl};
            n_cmp++;
            if (act !== 5'b00000) begin
                n_bad++;
                $display("FAIL reset cycle %0d: got %b expected 00000", c, act);
            end
        end
        do_reset();
    endtask

    task automatic test_single_press();
        logic [4:0] act, exp;
        int jcnt = 0;
        do_reset();
        bus.btn_on = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            @(negedge clk);
            act = {bus.j, bus.k, bus.conflict, bus.on_lvl, bus.off_lvl};
            exp = {(e == 7), 1'b0, 1'b0, (e >= 6), 1'b0};
            n_cmp++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL single_press edge %0d: got %b expected %b", e, act, exp);
            end
            if (bus.j === 1'b1) jcnt++;
        end
        n_cmp++;
        if (jcnt != 1) begin
            n_bad++;
            $display("FAIL single_press j count: got %0d expected 1", jcnt);
        end
    endtask

    task automatic test_glitch();
        logic [2:0] act;
        do_reset();
        for (int e = 1; e <= 16; e++) begin
            bus.btn_off = (e <= 3);
            @(negedge clk);
            act = {bus.off_lvl, bus.k, bus.conflict};
            n_cmp++;
            if (act !== 3'b000) begin
                n_bad++;
                $display("FAIL glitch edge %0d: got %b expected 000", e, act);
            end
        end
    endtask

    task automatic test_bounce();
        logic [4:0] pat = 5'b01101; // applied LSB first: 1,0,1,1,0
        int jcnt = 0;
        do_reset();
        for (int e = 1; e <= 20; e++) begin
            bus.btn_on = (e <= 5) ? pat[e-1] : 1'b1;
            @(negedge clk);
            n_cmp++;
            if (bus.j !== (e == 12)) begin
                n_bad++;
                $display("FAIL bounce edge %0d: got j=%b expected %b", e, bus.j, (e == 12));
            end
            if (bus.j === 1'b1) jcnt++;
        end
        n_cmp++;
        if (jcnt != 1) begin
            n_bad++;
            $display("FAIL bounce j count: got %0d expected 1", jcnt);
        end
    endtask

    task automatic test_simultaneous();
        logic [2:0] act, exp;
        do_reset();
        bus.btn_on  = 1'b1;
        bus.btn_off = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            @(negedge clk);
            act = {bus.j, bus.k, bus.conflict};
            exp = {1'b0, 1'b0, (e == 7)};
            n_cmp++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL simultaneous edge %0d: got %b expected %b", e, act, exp);
            end
        end
    endtask

    task automatic test_staggered();
        logic [2:0] act, exp;
        do_reset();
        bus.btn_on = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            @(negedge clk);
            bus.btn_off = 1'b1;
            act = {bus.j, bus.k, bus.conflict};
            exp = {(e == 7), (e == 8), 1'b0};
            n_cmp++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL staggered edge %0d: got %b expected %b", e, act, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] act;
        do_reset();
        bus.btn_on = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        act = {bus.j, bus.k, bus.conflict, bus.on_lvl, bus.off_lvl};
        n_cmp++;
        if (act !== 5'b00000) begin
            n_bad++;
            $display("FAIL reset_mid async clear: got %b expected 00000", act);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.j !== (e == 7)) begin
                n_bad++;
                $display("FAIL reset_mid edge %0d: got j=%b expected %b", e, bus.j, (e == 7));
            end
        end
    endtask

    task automatic test_random();
        logic [4:0] act, exp;
        int run_on = 0, run_off = 0;
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            if (run_on == 0) begin
                bus.btn_on = 1'($urandom_range(0, 1));
                run_on = $urandom_range(1, 12);
            end
            if (run_off == 0) begin
                bus.btn_off = 1'($urandom_range(0, 1));
                run_off = $urandom_range(1, 12);
            end
            run_on--;
            run_off--;
            @(negedge clk);
            act = {bus.j, bus.k, bus.conflict, bus.on_lvl, bus.off_lvl};
            exp = {m_j, m_k, m_conf, m_lvl[0], m_lvl[1]};
            n_cmp++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL random cycle %0d: got %b expected %b", c, act, exp);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.btn_on  = 1'b0;
        bus.btn_off = 1'b0;
        test_reset();
        test_single_press();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_staggered();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
